dct_coef_packer: RTL and testbench
==================================

DCT_COEF_PACKER -- requirements
Module: dct_coef_packer

Interface
REQ-001 Parameter NCOEF, default 5, number of coefficients per DCT block.
REQ-002 Parameter QSHIFT, default 5, quantisation right-shift amount (0..12).
REQ-003 Parameter OUT_W, default 12, signed width of each quantised coefficient.
REQ-004 clk  input  1  clock; all logic is rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 coef_in  input  18  signed coefficient from the upstream DCT stage.
REQ-007 coef_done  input  1  upstream strobe; coef_in is valid in any cycle where coef_done rises.
REQ-008 m_data  output  OUT_W  quantised signed coefficient.
REQ-009 m_idx  output  3  coefficient index 0..NCOEF-1 within the block.
REQ-010 m_last  output  1  high with the beat where m_idx==NCOEF-1.
REQ-011 m_valid  output  1  output beat valid.
REQ-012 m_ready  input  1  downstream accepts the beat when m_valid and m_ready are both high.
REQ-013 overflow  output  1  sticky flag set when a coefficient is dropped.

Function
REQ-014 Capture shall occur only on the rising edge of coef_done (registered previous value); a level held high for several cycles counts once.
REQ-015 Quantise: q = (coef_in + 2^(QSHIFT-1)) >>> QSHIFT (arithmetic shift, round half up); with QSHIFT=0, q = coef_in.
REQ-016 Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; compute the rounding add at 19 bits so that no wrap occurs.
REQ-017 The quantised value shall be written into the current write bank at position wr_cnt; wr_cnt increments and wraps from NCOEF-1 to 0.
REQ-018 Two banks (ping-pong), each holding NCOEF entries; a bank_full flag per bank.
REQ-019 On the write of entry NCOEF-1, the write bank's full flag shall be set and the write pointer shall toggle to the other bank.
REQ-020 If a capture targets a bank whose full flag is set, the coefficient shall be dropped, overflow set, and wr_cnt left unchanged.
REQ-021 Read FSM states: IDLE and SEND.
REQ-022 IDLE -> SEND when the read bank's full flag is set; m_valid rises in the cycle after the flag is seen.
REQ-023 In SEND, m_valid=1, m_data/m_idx come from the read bank at rd_cnt, and m_last=(rd_cnt==NCOEF-1).
REQ-024 Outputs shall stay stable while m_valid && !m_ready.
REQ-025 On handshake: rd_cnt increments; on the last beat, clear the read bank's full flag, toggle the read pointer, reset rd_cnt to 0, and go to IDLE.
REQ-026 A capture and a read-bank release in the same cycle on the same bank: the release wins first, and the capture is accepted without overflow.
REQ-027 Minimum latency from the rising edge of the capture of entry NCOEF-1 to the first m_valid: 2 cycles.
REQ-028 Sustained throughput: one beat per cycle while m_ready=1.

Reset
REQ-029 On rst: m_valid=0, m_data=0, m_idx=0, m_last=0, overflow=0, both full flags=0, wr/rd bank pointers=0, wr_cnt=rd_cnt=0, FSM=IDLE, coef_done history=0.
REQ-030 rst mid-block shall discard partial and full banks; the first rising edge of coef_done after reset writes bank 0, index 0.
REQ-031 overflow shall clear only on rst.

Structure
REQ-032 The shared package dct_pkg shall hold NCOEF, COEF_W=18, OUT_W, QSHIFT defaults and the read-FSM state typedef.
REQ-033 Quantise/saturate shall be a combinational sub-module dct_quant (18-bit in, OUT_W out, QSHIFT parameter).

Verification
REQ-034 Five coef_done pulses, values 32, -32, 48, 65535, -131072, m_ready=1 -> beats 1, -1, 2 (round half up), 2047 (saturated), -2048 (saturated); idx 0..4; m_last on idx 4.
REQ-035 coef_done held high for 3 cycles with coef_in=64 -> exactly one capture, value 2.
REQ-036 m_ready=0 across 12 capture edges -> the first 10 are stored; the 11th and 12th are dropped; overflow=1; then m_ready=1 -> 10 beats in order, two m_last pulses.
REQ-037 m_ready toggling 1,0,1,0 -> m_data/m_idx held during stall cycles; no beat duplicated or skipped.
REQ-038 rst asserted after 3 captures -> all outputs 0; the next 5 captures produce one block with idx 0..4.
REQ-039 Bank 0 in its last handshake cycle coincides with a capture into bank 0 (bank 1 full) -> capture accepted, overflow stays 0.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared defaults and read-FSM state encoding for the DCT coefficient packer.
// The defaults carry a _DEF suffix so the modules can expose same-named parameters.
package dct_pkg;

    localparam int NCOEF_DEF  = 5;
    localparam int COEF_W     = 18;
    localparam int OUT_W_DEF  = 12;
    localparam int QSHIFT_DEF = 5;
    localparam int IDX_W      = 3;

    typedef logic [0:0] rd_state_t;
    localparam rd_state_t ST_IDLE = 1'b0;
    localparam rd_state_t ST_SEND = 1'b1;

endpackage

// File: rtl/dct_quant.sv
// Combinational quantiser: round-half-up arithmetic right shift followed by
// saturation to a signed OUT_W result.
module dct_quant
    import dct_pkg::*;
#(
    parameter int QSHIFT = QSHIFT_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic [COEF_W-1:0] coef,
    output logic [OUT_W-1:0]  q
);

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    localparam int SUM_W = COEF_W + 1;
    localparam logic signed [SUM_W-1:0] MAX_Q = SUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_Q = SUM_W'(-(1 << (OUT_W - 1)));

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;

    generate
        if (QSHIFT == 0) begin : g_pass
            assign sum = {coef[COEF_W-1], coef};
        end else begin : g_round
            localparam logic [SUM_W-1:0] RND = SUM_W'(1) << (QSHIFT - 1);
            assign sum = {coef[COEF_W-1], coef} + RND;
        end
    endgenerate

    assign shifted = sum >>> QSHIFT;

    // NOTE: every branch assigns q, so this stays pure combinational logic with no latch.
    always_comb begin
        if (shifted > MAX_Q) begin
            q = MAX_Q[OUT_W-1:0];
        end else if (shifted < MIN_Q) begin
            q = MIN_Q[OUT_W-1:0];
        end else begin
            q = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/dct_coef_packer.sv
// Captures quantised DCT coefficients into ping-pong banks and streams each
// complete block out over a valid/ready interface, dropping input when both banks are full.
module dct_coef_packer
    import dct_pkg::*;
#(
    parameter int NCOEF  = NCOEF_DEF,
    parameter int QSHIFT = QSHIFT_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COEF_W-1:0] coef_in,
    input  logic              coef_done,
    output logic [OUT_W-1:0]  m_data,
    output logic [IDX_W-1:0]  m_idx,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              overflow
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCOEF - 1);

    logic             done_q;
    logic             cap;
    logic [OUT_W-1:0] q;

    logic [OUT_W-1:0] bank [2][NCOEF];
    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] wr_cnt;
    logic [IDX_W-1:0] rd_cnt;
    rd_state_t        state;

    logic hs;
    logic release_rd;
    logic wr_ok;
    logic wr_en;
    logic wr_last;

    dct_quant #(
        .QSHIFT (QSHIFT),
        .OUT_W  (OUT_W)
    ) u_quant (
        .coef (coef_in),
        .q    (q)
    );

    assign cap        = coef_done & ~done_q;
    assign hs         = (state == ST_SEND) & m_ready;
    assign release_rd = hs & (rd_cnt == LAST_IDX);
    // A bank being released this very cycle is already free for the incoming capture.
    assign wr_ok      = ~full[wr_bank] | (release_rd & (rd_bank == wr_bank));
    assign wr_en      = cap & wr_ok;
    assign wr_last    = wr_en & (wr_cnt == LAST_IDX);

    // NOTE: bank storage has no reset; the full flags gate every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank[wr_bank][wr_cnt] <= q;
        end
    end

    // NOTE: non-blocking updates let the release and the set of full[] coexist; the later set wins on a shared bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q   <= 1'b0;
            overflow <= 1'b0;
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            state    <= ST_IDLE;
        end else begin
            done_q <= coef_done;

            if (cap && !wr_ok) begin
                overflow <= 1'b1;
            end

            if (wr_en) begin
                wr_cnt <= wr_last ? '0 : wr_cnt + IDX_W'(1);
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end

            if (release_rd) begin
                full[rd_bank] <= 1'b0;
            end
            if (wr_last) begin
                full[wr_bank] <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (full[rd_bank]) begin
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (hs) begin
                        if (rd_cnt == LAST_IDX) begin
                            rd_cnt  <= '0;
                            rd_bank <= ~rd_bank;
                            state   <= ST_IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + IDX_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are driven from held state only, so they cannot move during a stall.
    assign m_valid = (state == ST_SEND);
    assign m_data  = m_valid ? bank[rd_bank][rd_cnt] : '0;
    assign m_idx   = m_valid ? rd_cnt : '0;
    assign m_last  = m_valid & (rd_cnt == LAST_IDX);

endmodule

// File: tb/tb_dct_coef_packer.sv
// Self-checking bench for dct_coef_packer: table-driven quantisation vectors,
// scoreboard of expected beats, and directed stall/overflow/reset/release sequences.
module tb_dct_coef_packer;
    import dct_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] coef_in;
    logic        coef_done;
    logic [11:0] m_data;
    logic [2:0]  m_idx;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic        overflow;

    always #5 clk = ~clk;

    dct_coef_packer dut (
        .clk       (clk),
        .rst       (rst),
        .coef_in   (coef_in),
        .coef_done (coef_done),
        .m_data    (m_data),
        .m_idx     (m_idx),
        .m_last    (m_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .overflow  (overflow)
    );

    typedef struct {
        int coef;
        int exp_q;
    } vec_t;

    typedef struct {
        logic [11:0] data;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    exp_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_q(input int v);
        int r;
        r = (v + 16) >>> 5;
        if (r > 2047) r = 2047;
        else if (r < -2048) r = -2048;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input int q);
        beat_t b;
        b.data = 12'(q);
        b.idx  = 3'(exp_idx);
        b.last = (exp_idx == 4);
        sb.push_back(b);
        exp_idx = (exp_idx == 4) ? 0 : exp_idx + 1;
    endtask

    task automatic capture(input int v, input bit push, input int q);
        if (push) expect_beat(q);
        coef_in   = 18'(v);
        coef_done = 1'b1;
        tick();
        coef_done = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input int budget);
        int cyc = 0;
        while (sb.size() > 0 && cyc < budget) begin
            tick();
            cyc++;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    // Scoreboard monitor: samples on the falling edge, ahead of the handshake edge.
    always @(negedge clk) begin
        if (!rst && m_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got idx %0d data 0x%0h, required no beat", m_idx, m_data);
            end else begin
                mon_e = sb[0];
                check(m_ready ? "beat_data" : "stall_data", 32'(m_data), 32'(mon_e.data));
                check(m_ready ? "beat_idx" : "stall_idx", 32'(m_idx), 32'(mon_e.idx));
                check(m_ready ? "beat_last" : "stall_last", 32'(m_last), 32'(mon_e.last));
                if (m_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        bit   hit;

        tbl[0] = '{32, 1};
        tbl[1] = '{-32, -1};
        tbl[2] = '{48, 2};
        tbl[3] = '{65535, 2047};
        tbl[4] = '{-131072, -2048};
        tbl[5] = '{15, 0};
        tbl[6] = '{16, 1};
        tbl[7] = '{-16, 0};
        tbl[8] = '{-17, -1};
        tbl[9] = '{131071, 2047};

        rst = 1'b1; coef_done = 1'b0; coef_in = '0; m_ready = 1'b1;
        tick();
        tick();
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_m_idx", 32'(m_idx), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;
        tick();

        // Quantisation table; last entry of each block also checks the 2-cycle latency.
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) begin
                expect_beat(tbl[i].exp_q);
                coef_in   = 18'(tbl[i].coef);
                coef_done = 1'b1;
                tick();
                check("latency_early", 32'(m_valid), 0);
                coef_done = 1'b0;
                tick();
                check("latency_2cyc", 32'(m_valid), 1);
            end else begin
                capture(tbl[i].coef, 1'b1, tbl[i].exp_q);
            end
        end
        wait_drain(40);
        check("no_overflow_table", 32'(overflow), 0);

        // Level held for three cycles counts as a single capture.
        expect_beat(2);
        coef_in   = 18'(64);
        coef_done = 1'b1;
        tick(); tick(); tick();
        coef_done = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            int v = int'($urandom_range(200000)) - 100000;
            capture(v, 1'b1, model_q(v));
        end
        wait_drain(40);
        check("no_overflow_held", 32'(overflow), 0);

        // Both banks fill while stalled; captures 11 and 12 are dropped.
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            capture(i * 32 - 160, i < 10, i - 5);
        end
        check("overflow_set", 32'(overflow), 1);
        m_ready = 1'b1;
        wait_drain(60);
        check("overflow_sticky", 32'(overflow), 1);

        // Alternating ready: stalled beats must match the pending scoreboard head.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            capture(i * 100 + 7, 1'b1, model_q(i * 100 + 7));
        end
        for (int k = 0; k < 40 && sb.size() > 0; k++) begin
            m_ready = (k % 2 == 0);
            tick();
        end
        m_ready = 1'b1;
        wait_drain(20);

        // Reset mid-block discards the partial bank.
        for (int i = 0; i < 3; i++) begin
            capture(999, 1'b0, 0);
        end
        rst = 1'b1;
        tick();
        check("rst2_m_valid", 32'(m_valid), 0);
        check("rst2_m_data", 32'(m_data), 0);
        check("rst2_m_idx", 32'(m_idx), 0);
        check("rst2_m_last", 32'(m_last), 0);
        check("rst2_overflow", 32'(overflow), 0);
        rst = 1'b0;
        sb.delete();
        exp_idx = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            capture(-(i * 64) - 1, 1'b1, model_q(-(i * 64) - 1));
        end
        wait_drain(40);

        // Capture into bank 0 on the same edge that bank 0 releases its last beat.
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            capture(i * 40, 1'b1, model_q(i * 40));
        end
        check("both_full_no_ovf", 32'(overflow), 0);
        m_ready = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (m_valid && m_idx == 3'd4) begin
                expect_beat(model_q(224));
                coef_in   = 18'(224);
                coef_done = 1'b1;
                hit = 1'b1;
                tick();
                coef_done = 1'b0;
                tick();
            end else begin
                tick();
            end
        end
        check("coincide_reached", 32'(hit), 1);
        check("coincide_no_ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            capture(1000 + i * 33, 1'b1, model_q(1000 + i * 33));
        end
        wait_drain(60);
        check("final_no_ovf", 32'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
